synchronous_fifo: RTL and testbench

Single-clock first-in/first-out buffer of DEPTH entries, each WIDTH bits, with registered read data and full/empty status flags. It decouples a producer and a consumer that share one clock domain. Writes are dropped when full and reads are ignored when empty, so the block can never overflow or underflow internally.

---
 rtl/synchronous_fifo.sv | 62 ++++++
 tb/tb_synchronous_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO, DEPTH x WIDTH, registered dout.
// Ports: clk, rst (sync, active-high), wr_en/din/full, rd_en/dout/empty.
module synchronous_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses the registered flags, so no input reaches a flag.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Array is not reset; stale entries become unreachable after rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb_synchronous_fifo: directed + random stimulus against a queue model.
// Checks dout/full/empty one time unit after every rising edge.
module tb_synchronous_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             full;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] dm = '0;

  synchronous_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .full  (full),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},  32'(dout),  32'(dm));
    check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
  endtask

  task automatic step(input string tag, input logic w,
                      input logic [WIDTH-1:0] d, input logic r);
    int pre;
    @(negedge clk);
    rst = 1'b0; wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    #1;
    pre = q.size();
    if (r && pre > 0) dm = q.pop_front();
    if (w && pre < DEPTH) q.push_back(d);
    check_all(tag);
  endtask

  // Reset with requests held high: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    din = WIDTH'($urandom);
    @(posedge clk);
    #1;
    q.delete();
    dm = '0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    do_reset("rst0");

    step("w124", 1'b1, 8'd124, 1'b0);
    step("r124", 1'b0, 8'd0, 1'b1);
    check("r124.val", 32'(dout), 32'd124);

    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, WIDTH'($urandom), 1'b0);
      if ($urandom_range(1, 0) == 1) step("idle", 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("wrapw", 1'b1, WIDTH'(i), 1'b0);
    step("wrapr0", 1'b0, '0, 1'b1);
    check("wrap.d0", 32'(dout), 32'd0);
    step("wrapr1", 1'b0, '0, 1'b1);
    check("wrap.d1", 32'(dout), 32'd1);
    step("wrap77", 1'b1, 8'h77, 1'b0);
    for (int i = 2; i < DEPTH; i++) begin
      step("wrapr", 1'b0, '0, 1'b1);
      check("wrap.seq", 32'(dout), 32'(i));
    end
    step("wraplast", 1'b0, '0, 1'b1);
    check("wrap.77", 32'(dout), 32'h77);

    step("sim55", 1'b1, 8'h55, 1'b0);
    step("simwr", 1'b1, 8'h99, 1'b1);
    check("sim.55", 32'(dout), 32'h55);
    check("sim.cnt1", 32'(empty), 32'd0);
    step("sim99", 1'b0, '0, 1'b1);
    check("sim.99", 32'(dout), 32'h99);

    step("simempty", 1'b1, 8'h3c, 1'b1);
    step("simempty_r", 1'b0, '0, 1'b1);

    for (int i = 0; i < DEPTH + 2; i++)
      step("ovf", 1'b1, WIDTH'($urandom), 1'b0);
    step("fullrw", 1'b1, 8'haa, 1'b1);
    step("fullrw2", 1'b1, 8'hbb, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("ovfdrain", 1'b0, '0, 1'b1);
    step("udf1", 1'b0, '0, 1'b1);
    step("udf2", 1'b0, '0, 1'b1);

    for (int i = 0; i < 12; i++)
      step("pre_rst", 1'b1, WIDTH'($urandom), 1'b0);
    do_reset("rst_mid");
    step("post_rst_rd", 1'b0, '0, 1'b1);
    check("post_rst.dout", 32'(dout), 32'd0);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), WIDTH'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
